vram_scheduler: RTL and testbench
=================================

Name: vram_scheduler

Overview:
Time-multiplexes one single-port synchronous pixel RAM between two users: VGA scan-out reads and game-logic writes.
- Consumes the strobes and counters of the VGA timing generator (pixclk, x, y, valid).
- Issues exactly one display read per visible pixel; those reads are never delayed.
- Grants write requests only in slots the display does not use.
- Framebuffer is a downscaled image (default 160x120, 4x4 pixel replication onto 640x480).

Parameters:
- SCALE_SHIFT, 2, log2 of pixel replication; FB_W = 640>>SCALE_SHIFT, FB_H = 480>>SCALE_SHIFT.
- DATA_W, 8, bits per framebuffer pixel.
- ADDR_W, 15, RAM address width; must satisfy 2^ADDR_W >= FB_W*FB_H.

Ports:
- clk  in  1  system clock (50 MHz)
- rst  in  1  synchronous, active-high reset
- pixclk  in  1  one-cycle strobe from VGA timing; x/y already hold the new pixel when high
- x  in  10  current VGA column
- y  in  10  current VGA row
- valid  in  1  x<640 && y<480
- wr_req  in  1  writer request; level, held until wr_ack
- wr_addr  in  ADDR_W  write address; stable while wr_req && !wr_ack
- wr_data  in  DATA_W  write data; stable with wr_addr
- wr_ack  out  1  one-cycle pulse, write committed this cycle
- wr_err  out  1  sticky; out-of-range write seen
- ram_en  out  1  RAM enable
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, one cycle after ram_en && !ram_we
- pix_data  out  DATA_W  pixel for display
- pix_valid  out  1  pix_data corresponds to a visible pixel

Behaviour:
Reset:
- All outputs 0.
- FSM state IDLE; read-tag pipeline cleared.
- A write whose ack has not yet been issued is abandoned; the writer re-presents it.

Decision cycle D: one decision per clk.
- Display slot: pixclk && valid. Issue read; addr = (y>>SCALE_SHIFT)*FB_W + (x>>SCALE_SHIFT), computed as shift-add, truncated to ADDR_W.
- Write slot: !pixclk && wr_req && !wr_ack. Grant the write.
- Otherwise: ram_en = 0.
- pixclk cycles never carry writes, even when valid = 0. This keeps the slot pattern fixed.
- No grant in a cycle where wr_ack is high. Maximum one write per 2 clk.

FSM states, one per issued operation:
- IDLE: ram_en = 0.
- RD: ram_en = 1, ram_we = 0.
- WR: ram_en = 1, ram_we = 1, wr_ack = 1.
- Next state is selected by the decision in cycle D; the state register and ram_* are registered, so they hold during D+1.

Read latency:
- ram_* driven in D+1.
- ram_rdata valid in D+2.
- pix_data/pix_valid registered, valid in D+3. Fixed 3 clk; the display path delays hsync/vsync/valid by 3 to match.
- pix_valid = 1 only for cycles tagged as display reads. pix_data holds its value otherwise.

Out-of-range write (wr_addr >= FB_W*FB_H):
- Still acked, with ram_en = 0 and ram_we = 0.
- wr_err set; cleared only by rst.

Simultaneous events:
- wr_req rising in a pixclk cycle waits one clk.
- Line and frame wrap need no special handling; addressing follows x/y.

Optional Feature:
VRAM_VBLANK_WR_EN
- Defined: write slots are granted only while y >= 480 (vertical blanking), giving tear-free updates. Requests made during the visible region stall until line 480, then are served at 1 per 2 clk.
- Undefined: writes are granted in any non-pixclk cycle.

Decomposition:
- Package vram_pkg: H_VIS=640, V_VIS=480, SCALE_SHIFT default, FB_W/FB_H, ADDR_W, DATA_W, FSM state enum {IDLE, RD, WR}.
- Sub-module vram_addr_gen: combinational (x,y) -> read address via shift-add, plus a range check reused for wr_addr.

Test Plan:
1. rst held with wr_req=1 -> all outputs 0; after release, first grant on the first non-pixclk cycle; wr_ack exactly 1 cycle wide.
2. x=5, y=9 visible, pixclk=1 at cycle D -> ram_addr=2*160+1=321 with ram_we=0 at D+1; ram_rdata=0xA5 at D+2 -> pix_data=0xA5, pix_valid=1 at D+3.
3. wr_req held continuously with alternating pixclk -> no write ever in a pixclk cycle; display read issued every pixclk; writes at most 1 per 2 clk.
4. wr_addr=19200 (out of range) -> wr_ack pulses, ram_en stays 0, wr_err=1 and remains 1 until rst.
5. valid=0 (x=700) with pixclk=1 -> no RAM access, pix_valid=0 three cycles later; a pending write is still not granted in that cycle.
6. With VRAM_VBLANK_WR_EN defined, wr_req at y=100 -> no ack until y=480; then ack on the first non-pixclk cycle.

Source files
------------

// File: rtl/vram_pkg.sv
// ---------------------------------------------------------------------------
// vram_pkg
// Shared constants and types for the VRAM scheduler.
//   H_VIS / V_VIS        : visible VGA resolution (640x480)
//   DEF_SCALE_SHIFT      : default log2 pixel replication
//   DEF_FB_W / DEF_FB_H  : default framebuffer size
//   DEF_DATA_W / DEF_ADDR_W : default pixel and RAM address widths
//   state_t              : scheduler FSM state (one state per issued RAM op)
//   fb_size()            : number of framebuffer pixels for a given shift
// ---------------------------------------------------------------------------
package vram_pkg;

    localparam int H_VIS           = 640;
    localparam int V_VIS           = 480;
    localparam int DEF_SCALE_SHIFT = 2;
    localparam int DEF_FB_W        = H_VIS >> DEF_SCALE_SHIFT;
    localparam int DEF_FB_H        = V_VIS >> DEF_SCALE_SHIFT;
    localparam int DEF_DATA_W      = 8;
    localparam int DEF_ADDR_W      = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } state_t;

    function automatic int fb_size(input int shift);
        return (H_VIS >> shift) * (V_VIS >> shift);
    endfunction

endpackage

// File: rtl/vram_addr_gen.sv
// ---------------------------------------------------------------------------
// vram_addr_gen
// Combinational address helper for the VRAM scheduler.
//   x, y        : current VGA column/row
//   wr_addr     : writer address to be range-checked
//   rd_addr     : framebuffer read address for (x, y), truncated to ADDR_W
//   wr_in_range : wr_addr lies inside the framebuffer
// ---------------------------------------------------------------------------
module vram_addr_gen
    import vram_pkg::*;
#(
    parameter int SCALE_SHIFT = DEF_SCALE_SHIFT,
    parameter int ADDR_W      = DEF_ADDR_W
) (
    input  logic [9:0]        x,
    input  logic [9:0]        y,
    input  logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              wr_in_range
);

    localparam int FB_SIZE = fb_size(SCALE_SHIFT);

    logic [9:0] col;
    logic [9:0] row;

    assign col = x >> SCALE_SHIFT;
    assign row = y >> SCALE_SHIFT;

    // FB_W = (512 + 128) >> SCALE_SHIFT, so row * FB_W becomes two shifts
    // and an add (holds for SCALE_SHIFT <= 7).
    assign rd_addr = ADDR_W'((32'(row) << (9 - SCALE_SHIFT))
                           + (32'(row) << (7 - SCALE_SHIFT))
                           + 32'(col));

    assign wr_in_range = (32'(wr_addr) < 32'(FB_SIZE));

endmodule

// File: rtl/vram_scheduler.sv
// ---------------------------------------------------------------------------
// vram_scheduler
// Shares one single-port synchronous pixel RAM between VGA scan-out reads
// and game-logic writes. Every visible pixclk cycle issues a display read
// that is never delayed; writes use only non-pixclk cycles, at most one per
// two clocks. Display pixels appear a fixed 3 clocks after the pixclk cycle.
//
// Optional build macro: VRAM_VBLANK_WR_EN
//   defined   : writes granted only while y >= 480 (vertical blanking)
//   undefined : writes granted in any non-pixclk cycle
//
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   pixclk, x, y, valid    : VGA timing strobe and counters
//   wr_req/addr/data       : writer request (level, held until wr_ack)
//   wr_ack                 : one-cycle pulse, write committed this cycle
//   wr_err                 : sticky out-of-range write flag
//   ram_en/we/addr/wdata   : RAM command, registered
//   ram_rdata              : RAM read data, one cycle after a read
//   pix_data, pix_valid    : display pixel, 3 clocks after pixclk
// ---------------------------------------------------------------------------
module vram_scheduler
    import vram_pkg::*;
#(
    parameter int SCALE_SHIFT = DEF_SCALE_SHIFT,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ADDR_W      = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pixclk,
    input  logic [9:0]        x,
    input  logic [9:0]        y,
    input  logic              valid,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic              wr_err,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid
);

    logic [ADDR_W-1:0] rd_addr;
    logic              wr_in_range;
    logic              blank_ok;
    logic              rd_slot;
    logic              wr_slot;
    logic              rd_tag_p2;
    state_t            state;
    state_t            state_next;

    vram_addr_gen #(
        .SCALE_SHIFT (SCALE_SHIFT),
        .ADDR_W      (ADDR_W)
    ) u_addr_gen (
        .x           (x),
        .y           (y),
        .wr_addr     (wr_addr),
        .rd_addr     (rd_addr),
        .wr_in_range (wr_in_range)
    );

`ifdef VRAM_VBLANK_WR_EN
    assign blank_ok = (y >= 10'(V_VIS));
`else
    assign blank_ok = 1'b1;
`endif

    // pixclk cycles are reserved for the display even when not visible, so
    // the read/write slot pattern never shifts. The wr_ack term stops the
    // writer's still-asserted request from being granted twice.
    assign rd_slot = pixclk && valid;
    assign wr_slot = !pixclk && wr_req && !wr_ack && blank_ok;

    // ---- decision cycle D -> RAM command stage (D+1) ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = IDLE;
        if (rd_slot) begin
            state_next = RD;
        end else if (wr_slot && wr_in_range) begin
            state_next = WR;
        end
    end

    assign ram_en = (state != IDLE);
    assign ram_we = (state == WR);

    // Out-of-range writes are acked but leave the state IDLE, so the RAM
    // never sees them.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ack    <= 1'b0;
            wr_err    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            wr_ack <= wr_slot;
            if (wr_slot && !wr_in_range) begin
                wr_err <= 1'b1;
            end
            if (rd_slot) begin
                ram_addr <= rd_addr;
            end else if (wr_slot && wr_in_range) begin
                ram_addr  <= wr_addr;
                ram_wdata <= wr_data;
            end
        end
    end

    // ---- RAM data stage (D+2) -> display output stage (D+3) ----
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_tag_p2 <= 1'b0;
            pix_valid <= 1'b0;
            pix_data  <= '0;
        end else begin
            rd_tag_p2 <= (state == RD);
            pix_valid <= rd_tag_p2;
            if (rd_tag_p2) begin
                pix_data <= ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_vram_scheduler.sv
// ---------------------------------------------------------------------------
// tb_vram_scheduler
// Self-checking bench for vram_scheduler: directed vector table, hand-written
// multi-cycle sequences, and randomized traffic against a reference model.
// ---------------------------------------------------------------------------
module tb_vram_scheduler;
    import vram_pkg::*;

    localparam int AW = 15;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          pixclk;
    logic [9:0]    x;
    logic [9:0]    y;
    logic          valid;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ack;
    logic          wr_err;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic [DW-1:0] pix_data;
    logic          pix_valid;

    always #5 clk = ~clk;

    vram_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .pixclk    (pixclk),
        .x         (x),
        .y         (y),
        .valid     (valid),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ack    (wr_ack),
        .wr_err    (wr_err),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .pix_data  (pix_data),
        .pix_valid (pix_valid)
    );

    // Behavioural single-port RAM with a preload port for the bench.
    logic [DW-1:0] mem [0:32767];
    logic          pre_en;
    logic [AW-1:0] pre_addr;
    logic [DW-1:0] pre_val;

    always @(posedge clk) begin
        if (pre_en) mem[pre_addr] <= pre_val;
        if (ram_en && ram_we) mem[ram_addr] <= ram_wdata;
        if (ram_en && !ram_we) ram_rdata <= mem[ram_addr];
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pix(input bit px, input int xx, input int yy);
        pixclk = px;
        x      = 10'(xx);
        y      = 10'(yy);
        valid  = (xx < 640) && (yy < 480);
    endtask

    task automatic set_idle();
        set_pix(0, 700, 500);
        wr_req  = 0;
        wr_addr = '0;
        wr_data = '0;
        pre_en  = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        set_idle();
        tick();
        tick();
        rst = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " ram_en"},    32'(ram_en),    0);
        check({tag, " ram_we"},    32'(ram_we),    0);
        check({tag, " ram_addr"},  32'(ram_addr),  0);
        check({tag, " ram_wdata"}, 32'(ram_wdata), 0);
        check({tag, " wr_ack"},    32'(wr_ack),    0);
        check({tag, " wr_err"},    32'(wr_err),    0);
        check({tag, " pix_data"},  32'(pix_data),  0);
        check({tag, " pix_valid"}, 32'(pix_valid), 0);
    endtask

    typedef struct {
        bit pclk; int x; int y;
        bit req; int waddr; int wdata; int pre;
        bit e_en; bit e_we; int e_addr; int e_wd; bit e_ack; bit e_err;
        bit e_pv; int e_pd;
    } vec_t;

    typedef struct { bit v; logic [7:0] d; } pe_t;

    vec_t vt [9];
    logic [7:0] fb [0:639];
    pe_t pq [$];

    initial begin
        // {pclk,x,y, req,waddr,wdata,pre, en,we,addr,wd,ack,err, pv,pd}
        vt[0] = '{1, 5,   9,   0, 0,     0,    'hA5, 1, 0, 321,   0,    0, 0, 1, 'hA5};
        vt[1] = '{1, 639, 479, 0, 0,     0,    'h3C, 1, 0, 19199, 0,    0, 0, 1, 'h3C};
        vt[2] = '{1, 0,   0,   0, 0,     0,    'h11, 1, 0, 0,     0,    0, 0, 1, 'h11};
        vt[3] = '{1, 3,   3,   0, 0,     0,    'h99, 1, 0, 0,     0,    0, 0, 1, 'h99};
        vt[4] = '{1, 700, 10,  0, 0,     0,    0,    0, 0, 0,     0,    0, 0, 0, 0};
        vt[5] = '{0, 0,   500, 1, 100,   'h5A, 0,    1, 1, 100,   'h5A, 1, 0, 0, 0};
        vt[6] = '{0, 0,   500, 1, 19199, 'h77, 0,    1, 1, 19199, 'h77, 1, 0, 0, 0};
        vt[7] = '{0, 0,   500, 1, 19200, 'h12, 0,    0, 0, 0,     0,    1, 1, 0, 0};
        vt[8] = '{0, 0,   500, 0, 0,     0,    0,    0, 0, 0,     0,    0, 0, 0, 0};

        rst = 1;
        set_idle();

        // Reset held with a pending request: everything stays 0.
        wr_req  = 1;
        wr_addr = 15'd50;
        wr_data = 8'h42;
        for (int k = 0; k < 3; k++) begin
            pixclk = k[0];
            tick();
            check_all_zero("reset");
        end
        rst = 0;
        pixclk = 1;
        tick();
        check("post-reset pixclk ack", 32'(wr_ack), 0);
        check("post-reset pixclk en",  32'(ram_en), 0);
        pixclk = 0;
        tick();
        check("first grant ack",  32'(wr_ack),   1);
        check("first grant we",   32'(ram_we),   1);
        check("first grant addr", 32'(ram_addr), 50);
        check("first grant data", 32'(ram_wdata), 'h42);
        wr_req = 0;
        pixclk = 1;
        tick();
        check("ack width", 32'(wr_ack), 0);
        pixclk = 0;
        tick();
        check("ack after drop", 32'(wr_ack), 0);

        // Directed vector table.
        foreach (vt[i]) begin
            do_reset();
            if (vt[i].e_en && !vt[i].e_we) begin
                pre_en   = 1;
                pre_addr = AW'(vt[i].e_addr);
                pre_val  = DW'(vt[i].pre);
                tick();
                pre_en = 0;
            end
            set_pix(vt[i].pclk, vt[i].x, vt[i].y);
            wr_req  = vt[i].req;
            wr_addr = AW'(vt[i].waddr);
            wr_data = DW'(vt[i].wdata);
            tick();
            check($sformatf("vec%0d ram_en", i), 32'(ram_en), 32'(vt[i].e_en));
            check($sformatf("vec%0d ram_we", i), 32'(ram_we), 32'(vt[i].e_we));
            check($sformatf("vec%0d wr_ack", i), 32'(wr_ack), 32'(vt[i].e_ack));
            check($sformatf("vec%0d wr_err", i), 32'(wr_err), 32'(vt[i].e_err));
            if (vt[i].e_en) check($sformatf("vec%0d ram_addr", i), 32'(ram_addr), vt[i].e_addr);
            if (vt[i].e_we) check($sformatf("vec%0d ram_wdata", i), 32'(ram_wdata), vt[i].e_wd);
            set_idle();
            tick();
            tick();
            check($sformatf("vec%0d pix_valid", i), 32'(pix_valid), 32'(vt[i].e_pv));
            check($sformatf("vec%0d pix_data", i),  32'(pix_data),  vt[i].e_pd);
        end

        // Pending write during an invisible pixclk cycle waits one clock.
        do_reset();
        wr_req  = 1;
        wr_addr = 15'd60;
        wr_data = 8'h01;
        set_pix(1, 700, 500);
        tick();
        check("invis pixclk ack", 32'(wr_ack), 0);
        check("invis pixclk en",  32'(ram_en), 0);
        pixclk = 0;
        tick();
        check("invis next ack",  32'(wr_ack),   1);
        check("invis next addr", 32'(ram_addr), 60);
        wr_req = 0;
        tick();
        check("invis pix_valid", 32'(pix_valid), 0);

        // Continuous requests, no pixclk: grants on every other clock.
        do_reset();
        wr_req  = 1;
        wr_addr = 15'd200;
        for (int k = 0; k < 6; k++) begin
            tick();
            check($sformatf("back2back ack %0d", k), 32'(wr_ack), 32'(k % 2 == 0));
            check($sformatf("back2back we %0d", k),  32'(ram_we), 32'(k % 2 == 0));
            if (wr_ack) wr_addr = AW'(201 + k);
        end
        wr_req = 0;

        // Visible-region request.
        do_reset();
        wr_req  = 1;
        wr_addr = 15'd300;
        wr_data = 8'h33;
`ifdef VRAM_VBLANK_WR_EN
        for (int k = 0; k < 6; k++) begin
            set_pix(k[0], 10, 100);
            tick();
            check($sformatf("vblank stall %0d", k), 32'(wr_ack), 0);
        end
        set_pix(0, 0, 480);
        tick();
        check("vblank grant ack", 32'(wr_ack), 1);
        check("vblank grant we",  32'(ram_we), 1);
`else
        set_pix(0, 10, 100);
        tick();
        check("visible grant ack", 32'(wr_ack), 1);
        check("visible grant we",  32'(ram_we), 1);
`endif
        wr_req = 0;

        // Sticky error until reset.
        do_reset();
        wr_req  = 1;
        wr_addr = 15'd20000;
        set_pix(0, 700, 500);
        tick();
        check("oob ack", 32'(wr_ack), 1);
        check("oob en",  32'(ram_en), 0);
        check("oob err", 32'(wr_err), 1);
        wr_req = 0;
        tick();
        tick();
        tick();
        check("oob err sticky", 32'(wr_err), 1);
        do_reset();
        check("oob err cleared", 32'(wr_err), 0);

        // Randomized traffic against the reference model.
        do_reset();
        for (int a = 0; a < 640; a++) begin
            pre_en   = 1;
            pre_addr = AW'(a);
            pre_val  = DW'($urandom);
            fb[a]    = pre_val;
            tick();
        end
        pre_en = 0;
        tick();
        begin
            bit         exp_ack_prev = 0;
            bit         exp_err = 0;
            logic [7:0] last_pix = 0;
            pq.delete();
            pq.push_back('{0, 8'h00});
            pq.push_back('{0, 8'h00});
            for (int n = 0; n < 3000; n++) begin
                bit px, rd, blank, gr, inr, e_en, e_we;
                int xx, yy, raddr;
                pe_t pe;
                px = ($urandom % 8 == 0) ? 1'($urandom % 2) : 1'(n % 2);
                xx = int'($urandom % 800);
                yy = ($urandom % 4 == 0) ? 480 + int'($urandom % 45) : int'($urandom % 16);
                set_pix(px, xx, yy);
                if (!wr_req && $urandom % 3 == 0) begin
                    wr_req  = 1;
                    wr_addr = ($urandom % 8 == 0) ? AW'(19200 + $urandom % 100) : AW'($urandom % 640);
                    wr_data = DW'($urandom);
                end
                rd    = px && valid;
                raddr = (yy / 4) * 160 + xx / 4;
`ifdef VRAM_VBLANK_WR_EN
                blank = (yy >= 480);
`else
                blank = 1;
`endif
                gr   = !px && wr_req && !exp_ack_prev && blank;
                inr  = int'(wr_addr) < 19200;
                e_en = rd || (gr && inr);
                e_we = gr && inr;
                if (gr && !inr) exp_err = 1;
                if (rd) pq.push_back('{1, fb[raddr]});
                else    pq.push_back('{0, 8'h00});
                if (e_we) fb[wr_addr] = wr_data;
                tick();
                check("rand ram_en", 32'(ram_en), 32'(e_en));
                check("rand ram_we", 32'(ram_we), 32'(e_we));
                check("rand wr_ack", 32'(wr_ack), 32'(gr));
                check("rand wr_err", 32'(wr_err), 32'(exp_err));
                if (e_en) check("rand ram_addr", 32'(ram_addr), rd ? raddr : 32'(wr_addr));
                if (e_we) check("rand ram_wdata", 32'(ram_wdata), 32'(wr_data));
                pe = pq.pop_front();
                if (pe.v) last_pix = pe.d;
                check("rand pix_valid", 32'(pix_valid), 32'(pe.v));
                check("rand pix_data",  32'(pix_data),  32'(last_pix));
                exp_ack_prev = gr;
                if (wr_req && wr_ack) begin
                    if ($urandom % 2 == 0) begin
                        wr_addr = ($urandom % 8 == 0) ? AW'(19200 + $urandom % 100) : AW'($urandom % 640);
                        wr_data = DW'($urandom);
                    end else begin
                        wr_req = 0;
                    end
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
